// File: rtl/imm_decode_stage_pkg.sv
// Shared immediate-type codes, opcode constants and the staging-buffer entry layout
// used by the decode-side immediate staging stage.
package imm_decode_stage_pkg;

  localparam logic [2:0] IMM_NOIMM    = 3'd0;
  localparam logic [2:0] IMM_ITYPE    = 3'd1;
  localparam logic [2:0] IMM_STYPE    = 3'd2;
  localparam logic [2:0] IMM_SBTYPE   = 3'd3;
  localparam logic [2:0] IMM_UTYPE    = 3'd4;
  localparam logic [2:0] IMM_UJTYPE   = 3'd5;
  localparam logic [2:0] IMM_CSRITYPE = 3'd6;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  imm_type;
    logic        illegal;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{inst: 32'd0, pc: 32'd0, imm_type: IMM_NOIMM, illegal: 1'b0};

endpackage

// File: rtl/imm_decode_stage_imm_operand_unit.sv
// Immediate generator: rebuilds the 32-bit operand from instruction bits [31:7]
// according to the immediate type selected at enqueue time.
module imm_decode_stage_imm_operand_unit
  import imm_decode_stage_pkg::*;
(
  input  logic [31:7] in_bits,
  input  logic [2:0]  imm_type,
  output logic [31:0] imm
);

  always_comb begin
    imm = 32'd0;
    case (imm_type)
      IMM_ITYPE:    imm = {{21{in_bits[31]}}, in_bits[30:20]};
      IMM_STYPE:    imm = {{21{in_bits[31]}}, in_bits[30:25], in_bits[11:7]};
      IMM_SBTYPE:   imm = {{20{in_bits[31]}}, in_bits[7], in_bits[30:25], in_bits[11:8], 1'b0};
      IMM_UTYPE:    imm = {in_bits[31:12], 12'd0};
      IMM_UJTYPE:   imm = {{12{in_bits[31]}}, in_bits[19:12], in_bits[20], in_bits[30:21], 1'b0};
      // CSR immediate forms carry a zero-extended 5-bit value in the rs1 field.
      IMM_CSRITYPE: imm = {27'd0, in_bits[19:15]};
      default:      imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Two-entry decode staging buffer: classifies incoming opcodes, counts illegal ones and
// presents the head instruction with its decoded immediate to the ID/EX side.
module imm_decode_stage
  import imm_decode_stage_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CPU_CLK,
  input  logic             CPU_RST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_pc,
  output logic [2:0]       out_imm_type,
  output logic [31:0]      out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  // Handshake: a beat transfers on a side only in a cycle where valid and ready are both
  // high at the rising edge and flush is low; flush discards buffered and incoming beats.

  entry_t           buf_q [2];
  entry_t           head;
  entry_t           new_entry;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [1:0]       next_count;
  logic             in_ready_q;
  logic [CNT_W-1:0] ill_cnt_q;
  logic [2:0]       cls_type;
  logic             cls_illegal;
  logic             push;
  logic             pop;

  always_comb begin : classify
    cls_type    = IMM_NOIMM;
    cls_illegal = 1'b0;
    case (in_inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR: cls_type = IMM_ITYPE;
      OP_STORE:                 cls_type = IMM_STYPE;
      OP_BRANCH:                cls_type = IMM_SBTYPE;
      OP_LUI, OP_AUIPC:         cls_type = IMM_UTYPE;
      OP_JAL:                   cls_type = IMM_UJTYPE;
      OP_REG:                   cls_type = IMM_NOIMM;
      OP_SYSTEM:                cls_type = in_inst[14] ? IMM_CSRITYPE : IMM_NOIMM;
      default:                  cls_illegal = 1'b1;
    endcase
  end

  assign new_entry = '{inst: in_inst, pc: in_pc, imm_type: cls_type, illegal: cls_illegal};
  assign push      = in_valid & in_ready_q & ~flush;
  assign pop       = (count != 2'd0) & out_ready & ~flush;

  always_comb begin : count_next
    next_count = count;
    if (flush) begin
      next_count = 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   next_count = count + 2'd1;
        2'b01:   next_count = count - 2'd1;
        default: next_count = count;
      endcase
    end
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      for (int i = 0; i < 2; i++) buf_q[i] <= ENTRY_RESET;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      in_ready_q <= 1'b1;
      ill_cnt_q  <= '0;
    end else begin
      count      <= next_count;
      in_ready_q <= (next_count != 2'd2);
      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) begin
          buf_q[wr_ptr] <= new_entry;
          wr_ptr        <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
      end
      if (push && cls_illegal && (ill_cnt_q != {CNT_W{1'b1}})) ill_cnt_q <= ill_cnt_q + CNT_W'(1);
    end
  end

  assign head         = buf_q[rd_ptr];
  assign in_ready     = in_ready_q;
  assign out_valid    = (count != 2'd0);
  assign out_inst     = head.inst;
  assign out_pc       = head.pc;
  assign out_imm_type = head.imm_type;
  assign out_illegal  = head.illegal;
  assign illegal_cnt  = ill_cnt_q;

  imm_decode_stage_imm_operand_unit u_imm (
    .in_bits  (head.inst[31:7]),
    .imm_type (head.imm_type),
    .imm      (out_imm)
  );

endmodule
